clk_phase_meter_50k: RTL and testbench

- Receive-side counterpart of the 50 kHz delayed-clock divider in the 2ASK/QPSK chain.
- Samples an incoming divided clock, measures its period, high time and phase offset against a local free-running reference frame in the 50 MHz domain, and declares lock.
- Downstream demodulator logic uses the reported phase to align symbol sampling.

---
 rtl/clk_phase_meter_50k.sv | 177 +++++++++++++++++
 tb/tb_clk_phase_meter_50k.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/clk_phase_meter_50k.sv
// Phase/period/high-time meter for the incoming 50 kHz divided clock, with lock detection.
// Optional macro GLITCH_FILTER_EN adds a 3-sample level filter after the synchronizer.
module clk_phase_meter_50k #(
    parameter int HALF_PERIOD = 500,
    parameter int CNT_W       = 30,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk50m,
    input  logic             rst,
    input  logic             clk_in,
    output logic [CNT_W-1:0] phase,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             timeout
);

`ifdef GLITCH_FILTER_EN
    localparam int SYNC_LAT = 5;
`else
    localparam int SYNC_LAT = 3;
`endif
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] FRAME       = CNT_W'(2 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(4 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] LAT         = CNT_W'(SYNC_LAT);
    localparam logic [CNT_W-1:0] PER_MIN     = CNT_W'(2 * HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_MAX     = CNT_W'(2 * HALF_PERIOD + TOL);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

    logic [1:0] sync_reg;
    logic       lvl_reg, lvl_next;
    logic       rise_ev_reg, fall_ev_reg;

    always_ff @(posedge clk50m) begin
        if (rst) begin
            sync_reg    <= '0;
            lvl_reg     <= 1'b0;
            rise_ev_reg <= 1'b0;
            fall_ev_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], clk_in};
            lvl_reg     <= lvl_next;
            rise_ev_reg <= lvl_next & ~lvl_reg;
            fall_ev_reg <= ~lvl_next & lvl_reg;
        end
    end

`ifdef GLITCH_FILTER_EN
    // Level only moves after three consecutive equal synchronized samples.
    logic [1:0] hist_reg;

    always_ff @(posedge clk50m) begin
        if (rst) hist_reg <= '0;
        else     hist_reg <= {hist_reg[0], sync_reg[1]};
    end

    always_comb begin
        lvl_next = lvl_reg;
        if ({hist_reg, sync_reg[1]} == 3'b111)
            lvl_next = 1'b1;
        else if ({hist_reg, sync_reg[1]} == 3'b000)
            lvl_next = 1'b0;
    end
`else
    always_comb lvl_next = sync_reg[1];
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   ref_cnt_reg, per_cnt_reg, per_cnt_next;
    logic [GOOD_W-1:0]  good_reg, good_next;
    logic               rise_seen_reg, rise_seen_next;
    logic [CNT_W-1:0]   phase_next, period_next, high_time_next;
    logic               meas_valid_next, locked_next, period_err_next, timeout_next;
    logic               in_tol;
    logic [CNT_W-1:0]   phase_calc;

    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_reg     <= IDLE;
            ref_cnt_reg   <= '0;
            per_cnt_reg   <= '0;
            good_reg      <= '0;
            rise_seen_reg <= 1'b0;
            phase         <= '0;
            period        <= '0;
            high_time     <= '0;
            meas_valid    <= 1'b0;
            locked        <= 1'b0;
            period_err    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ref_cnt_reg   <= (ref_cnt_reg == FRAME_LAST) ? '0 : ref_cnt_reg + 1'b1;
            per_cnt_reg   <= per_cnt_next;
            good_reg      <= good_next;
            rise_seen_reg <= rise_seen_next;
            phase         <= phase_next;
            period        <= period_next;
            high_time     <= high_time_next;
            meas_valid    <= meas_valid_next;
            locked        <= locked_next;
            period_err    <= period_err_next;
            timeout       <= timeout_next;
        end
    end

    assign in_tol     = (per_cnt_reg >= PER_MIN) && (per_cnt_reg <= PER_MAX);
    // Undo the synchronizer latency so phase names the first-sampled-high cycle.
    assign phase_calc = (ref_cnt_reg >= LAT) ? ref_cnt_reg - LAT : ref_cnt_reg + FRAME - LAT;

    always_comb begin
        state_next      = state_reg;
        good_next       = good_reg;
        rise_seen_next  = rise_seen_reg;
        phase_next      = phase;
        period_next     = period;
        high_time_next  = high_time;
        meas_valid_next = 1'b0;
        locked_next     = locked;
        period_err_next = 1'b0;
        timeout_next    = 1'b0;
        // The event cycle itself counts, so a clear loads 1.
        per_cnt_next    = (per_cnt_reg == '1) ? per_cnt_reg : per_cnt_reg + 1'b1;

        if (rise_ev_reg) begin
            per_cnt_next   = CNT_W'(1);
            phase_next     = phase_calc;
            rise_seen_next = 1'b1;
            case (state_reg)
                IDLE: state_next = MEASURE;
                MEASURE: begin
                    period_next     = per_cnt_reg;
                    meas_valid_next = 1'b1;
                    if (in_tol) begin
                        if (good_reg == GOOD_LAST) begin
                            locked_next = 1'b1;
                            state_next  = TRACK;
                        end
                        good_next = good_reg + GOOD_W'(1);
                    end else begin
                        good_next       = '0;
                        period_err_next = 1'b1;
                    end
                end
                TRACK: begin
                    period_next     = per_cnt_reg;
                    meas_valid_next = 1'b1;
                    if (!in_tol) begin
                        locked_next     = 1'b0;
                        good_next       = '0;
                        period_err_next = 1'b1;
                        state_next      = MEASURE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && per_cnt_reg >= TIMEOUT_CNT) begin
            timeout_next = 1'b1;
            locked_next  = 1'b0;
            good_next    = '0;
            state_next   = IDLE;
        end

        if (fall_ev_reg && rise_seen_reg) begin
            high_time_next = per_cnt_reg;
            rise_seen_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_phase_meter_50k.sv
// Directed bench for clk_phase_meter_50k: lock, period error, tolerance edge, wrap, timeout, reset.
module tb_clk_phase_meter_50k;

`ifdef GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk50m = 1'b0;
    logic        rst = 1'b1;
    logic        clk_in = 1'b0;
    logic [29:0] phase, period, high_time;
    logic        meas_valid, locked, period_err, timeout;

    int checks = 0;
    int errors = 0;
    int next_edge = 0;

    clk_phase_meter_50k dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .clk_in    (clk_in),
        .phase     (phase),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .period_err(period_err),
        .timeout   (timeout)
    );

    always #10 clk50m = ~clk50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge just before the posedge with reference index 'target'.
    task automatic go(input int target);
        while (next_edge < target) begin
            @(negedge clk50m);
            next_edge++;
        end
    endtask

    task automatic rise_chk(input string tag, input int t, input int hi, input logic e_mv,
                            input int e_phase, input int e_period, input logic e_locked,
                            input logic e_perr);
        go(t);
        clk_in = 1'b1;
        go(t + LAT + 1);
        check({tag, ".meas_valid"}, 32'(meas_valid), 32'(e_mv));
        check({tag, ".phase"}, 32'(phase), 32'(e_phase));
        check({tag, ".period"}, 32'(period), 32'(e_period));
        check({tag, ".locked"}, 32'(locked), 32'(e_locked));
        check({tag, ".period_err"}, 32'(period_err), 32'(e_perr));
        $display("%s rise@%0d phase=%0d period=%0d mv=%0b locked=%0b perr=%0b",
                 tag, t, phase, period, meas_valid, locked, period_err);
        go(t + LAT + 2);
        check({tag, ".mv_pulse"}, 32'(meas_valid), 32'd0);
        check({tag, ".perr_pulse"}, 32'(period_err), 32'd0);
        go(t + hi);
        clk_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".phase"}, 32'(phase), 32'd0);
        check({tag, ".period"}, 32'(period), 32'd0);
        check({tag, ".high_time"}, 32'(high_time), 32'd0);
        check({tag, ".meas_valid"}, 32'(meas_valid), 32'd0);
        check({tag, ".locked"}, 32'(locked), 32'd0);
        check({tag, ".period_err"}, 32'(period_err), 32'd0);
        check({tag, ".timeout"}, 32'(timeout), 32'd0);
        $display("%s all outputs checked", tag);
    endtask

    initial begin
        repeat (3) @(negedge clk50m);
        check_zero("reset");
        rst = 1'b0;
        next_edge = 0;

        // Acquire: 1000-cycle period, 50% duty, first sampled high at ref 137.
        rise_chk("acq1", 137,  500, 1'b0, 137, 0,    1'b0, 1'b0);
        rise_chk("acq2", 1137, 500, 1'b1, 137, 1000, 1'b0, 1'b0);
        check("acq2.high_time", 32'(high_time), 32'd500);
        rise_chk("acq3", 2137, 500, 1'b1, 137, 1000, 1'b0, 1'b0);
        rise_chk("acq4", 3137, 500, 1'b1, 137, 1000, 1'b0, 1'b0);
        rise_chk("acq5", 4137, 500, 1'b1, 137, 1000, 1'b1, 1'b0);

        // One long period drops lock, then four good periods relock.
        rise_chk("long",  5142, 500, 1'b1, 142, 1005, 1'b0, 1'b1);
        rise_chk("rel1",  6142, 500, 1'b1, 142, 1000, 1'b0, 1'b0);
        rise_chk("rel2",  7142, 500, 1'b1, 142, 1000, 1'b0, 1'b0);
        rise_chk("rel3",  8142, 500, 1'b1, 142, 1000, 1'b0, 1'b0);
        rise_chk("rel4",  9142, 500, 1'b1, 142, 1000, 1'b1, 1'b0);

        // Tolerance edge: 1002 stays locked, 1003 is an error; 1002 counts toward relock.
        rise_chk("tol1002", 10144, 300, 1'b1, 144, 1002, 1'b1, 1'b0);
        rise_chk("tol1003", 11147, 500, 1'b1, 147, 1003, 1'b0, 1'b1);
        check("duty300.high_time", 32'(high_time), 32'd300);
        rise_chk("t1", 12149, 500, 1'b1, 149, 1002, 1'b0, 1'b0);
        rise_chk("t2", 13151, 500, 1'b1, 151, 1002, 1'b0, 1'b0);
        rise_chk("t3", 14153, 500, 1'b1, 153, 1002, 1'b0, 1'b0);
        rise_chk("t4", 15155, 500, 1'b1, 155, 1002, 1'b1, 1'b0);

        // Timeout: counter reaches 2000 cycles after the last rise event.
        go(15155 + LAT + 2000);
        check("to.before", 32'(timeout), 32'd0);
        check("to.locked_before", 32'(locked), 32'd1);
        go(15155 + LAT + 2001);
        check("to.pulse", 32'(timeout), 32'd1);
        check("to.locked", 32'(locked), 32'd0);
        check("to.period_hold", 32'(period), 32'd1002);
        check("to.phase_hold", 32'(phase), 32'd155);
        $display("timeout at edge %0d timeout=%0b locked=%0b", 15155 + LAT + 2000, timeout, locked);
        go(15155 + LAT + 2002);
        check("to.single", 32'(timeout), 32'd0);
        rise_chk("idle", 17500, 500, 1'b0, 500, 1002, 1'b0, 1'b0);

        // Rise sampled at ref 998: event lands after the frame wraps.
        rise_chk("wrap", 18998, 500, 1'b1, 998, 1498, 1'b0, 1'b1);
        rise_chk("w1", 19998, 500, 1'b1, 998, 1000, 1'b0, 1'b0);
        rise_chk("w2", 20998, 500, 1'b1, 998, 1000, 1'b0, 1'b0);
        rise_chk("w3", 21998, 500, 1'b1, 998, 1000, 1'b0, 1'b0);
        rise_chk("w4", 22998, 500, 1'b1, 998, 1000, 1'b1, 1'b0);

        // One-cycle reset mid-TRACK; reference frame restarts at 0.
        go(23600);
        rst = 1'b1;
        @(negedge clk50m);
        check_zero("midrst");
        rst = 1'b0;
        next_edge = 0;
        rise_chk("post1", 250,  500, 1'b0, 250, 0,    1'b0, 1'b0);
        rise_chk("post2", 1250, 500, 1'b1, 250, 1000, 1'b0, 1'b0);

`ifdef GLITCH_FILTER_EN
        go(1900);
        clk_in = 1'b1;
        go(1902);
        clk_in = 1'b0;
        go(1912);
        check("glitch.meas_valid", 32'(meas_valid), 32'd0);
        check("glitch.phase", 32'(phase), 32'd250);
        $display("glitch 2-cycle pulse phase=%0d", phase);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
